// File: rtl/timer_pkg.sv
// Shared register map and control-bit layout for the multi-channel timer.
package timer_pkg;

    // Per-channel register offsets within a 4-word channel window
    localparam logic [1:0] LIMIT_LO_OFS = 2'd0;
    localparam logic [1:0] LIMIT_HI_OFS = 2'd1;
    localparam logic [1:0] CTRL_OFS     = 2'd2;
    localparam logic [1:0] COUNT_LO_OFS = 2'd3;

    // Global register addresses
    localparam logic [4:0] STATUS_ADDR   = 5'd16;
    localparam logic [4:0] COUNT_HI_ADDR = 5'd17;
    localparam logic [4:0] PRESC_ADDR    = 5'd18;

    // CTRL register bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_CLK_EN   = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_W        = 4;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: limit/control registers, tick-driven counter,
// sticky pending flag and square-wave output.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              wr_limit_lo,
    input  logic              wr_limit_hi,
    input  logic              wr_ctrl,
    input  logic              clear,
    input  logic [15:0]       d_in,
    output logic [CW-1:0]     limit,
    output logic [CW-1:0]     count,
    output logic [CTRL_W-1:0] ctrl,
    output logic              pending,
    output logic              clk_out
);

    logic active;
    logic terminal;
    logic en_rise;

    // A channel advances only on a tick while enabled with a nonzero limit
    always_comb begin
        active   = tick & ctrl[CTRL_EN] & (limit != '0);
        terminal = active & (count == limit);
        en_rise  = wr_ctrl & d_in[CTRL_EN] & ~ctrl[CTRL_EN];
    end

    // Register writes, counting, terminal events and clock output
    always_ff @(posedge clk) begin
        if (!rst) begin
            limit   <= '0;
            count   <= '0;
            ctrl    <= '0;
            pending <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            if (wr_limit_lo) begin
                limit[15:0] <= d_in;
            end
            if (wr_limit_hi) begin
                limit[CW-1:16] <= d_in[CW-17:0];
            end

            if (wr_limit_lo || wr_limit_hi || en_rise) begin
                count <= '0;
            end else if (terminal) begin
                count <= '0;
            end else if (active) begin
                count <= count + CW'(1);
            end

            if (wr_ctrl) begin
                ctrl <= d_in[CTRL_W-1:0];
            end else if (terminal && !ctrl[CTRL_PERIODIC]) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            pending <= terminal | (pending & ~clear);

            if (!ctrl[CTRL_CLK_EN]) begin
                clk_out <= 1'b0;
            end else if (terminal) begin
                clk_out <= ~clk_out;
            end
        end
    end

endmodule

// File: rtl/multi_timer_peripheral.sv
// Multi-channel timer/interrupt peripheral on the J1 I/O bus: shared
// prescaler, NCH timer channels, register decode and registered read data.
module multi_timer_peripheral
    import timer_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int PW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cs,
    input  logic           rd,
    input  logic           wr,
    input  logic [4:0]     addr,
    input  logic [15:0]    d_in,
    output logic [15:0]    d_out,
    output logic [NCH-1:0] clk_out,
    output logic           irq
);

    logic              we;
    logic              re;
    logic              tick;
    logic [PW-1:0]     presc_reg;
    logic [PW-1:0]     presc_cnt;
    logic [CW-17:0]    count_hi;

    logic [CW-1:0]     ch_limit [NCH];
    logic [CW-1:0]     ch_count [NCH];
    logic [CTRL_W-1:0] ch_ctrl  [NCH];
    logic [NCH-1:0]    pending;
    logic [NCH-1:0]    irq_mask;
    logic [NCH-1:0]    wr_lo;
    logic [NCH-1:0]    wr_hi;
    logic [NCH-1:0]    wr_ctrl;
    logic [NCH-1:0]    clear;

    logic [15:0]       rdata;
    logic [CW-17:0]    sel_hi;
    logic              lo_read;

    // Bus strobes; a simultaneous read and write counts as a write only
    always_comb begin
        we    = cs & wr;
        re    = cs & rd & ~wr;
        tick  = (presc_cnt == presc_reg);
        clear = {NCH{we && (addr == STATUS_ADDR)}} & d_in[NCH-1:0];
    end

    // Shared prescaler; reprogramming it restarts the divide phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_reg <= '0;
            presc_cnt <= '0;
        end else if (we && (addr == PRESC_ADDR)) begin
            presc_reg <= d_in[PW-1:0];
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign wr_lo[g]    = we & ~addr[4] & (addr[3:2] == 2'(g)) & (addr[1:0] == LIMIT_LO_OFS);
        assign wr_hi[g]    = we & ~addr[4] & (addr[3:2] == 2'(g)) & (addr[1:0] == LIMIT_HI_OFS);
        assign wr_ctrl[g]  = we & ~addr[4] & (addr[3:2] == 2'(g)) & (addr[1:0] == CTRL_OFS);
        assign irq_mask[g] = ch_ctrl[g][CTRL_IRQ_EN];

        timer_channel #(
            .CW(CW)
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .wr_limit_lo(wr_lo[g]),
            .wr_limit_hi(wr_hi[g]),
            .wr_ctrl    (wr_ctrl[g]),
            .clear      (clear[g]),
            .d_in       (d_in),
            .limit      (ch_limit[g]),
            .count      (ch_count[g]),
            .ctrl       (ch_ctrl[g]),
            .pending    (pending[g]),
            .clk_out    (clk_out[g])
        );
    end

    // Read mux; unmapped addresses and absent channels read as zero
    always_comb begin
        rdata   = '0;
        sel_hi  = '0;
        lo_read = 1'b0;
        if (!addr[4]) begin
            for (int c = 0; c < NCH; c++) begin
                if (addr[3:2] == 2'(c)) begin
                    sel_hi = ch_count[c][CW-1:16];
                    case (addr[1:0])
                        LIMIT_LO_OFS: rdata = ch_limit[c][15:0];
                        LIMIT_HI_OFS: rdata = 16'(ch_limit[c][CW-1:16]);
                        CTRL_OFS:     rdata = 16'(ch_ctrl[c]);
                        COUNT_LO_OFS: begin
                            rdata   = ch_count[c][15:0];
                            lo_read = 1'b1;
                        end
                        default:      rdata = '0;
                    endcase
                end
            end
        end else begin
            case (addr)
                STATUS_ADDR:   rdata = 16'(pending);
                COUNT_HI_ADDR: rdata = 16'(count_hi);
                PRESC_ADDR:    rdata = 16'(presc_reg);
                default:       rdata = '0;
            endcase
        end
    end

    // Registered read data, COUNT_HI snapshot and interrupt output
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_out    <= '0;
            count_hi <= '0;
            irq      <= 1'b0;
        end else begin
            if (re) begin
                d_out <= rdata;
                if (lo_read) begin
                    count_hi <= sel_hi;
                end
            end
            irq <= |(pending & irq_mask);
        end
    end

endmodule

// File: doc/multi_timer_peripheral.md
Name: multi_timer_peripheral

Overview:
- Parametrised multi-channel timer/interrupt peripheral on the J1 I/O bus (cs/rd/wr/addr/d_in/d_out); next generation of the single counter + clock generator + interruptor set.
- Shared prescaler feeds NCH independent counters with programmable limits.
- Each channel runs one-shot or periodic, can drive a square-wave clock output, and can raise a maskable interrupt.
- Pending flags are sticky, write-1-to-clear.

Parameters:
- NCH, 4, number of channels (1..4)
- CW, 32, channel counter/limit width (17..32)
- PW, 16, prescaler width (1..16)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when rst=0, sampled on rising clk)
- cs  in  1  chip select
- rd  in  1  read strobe
- wr  in  1  write strobe
- addr  in  5  register address
- d_in  in  16  write data
- d_out  out  16  registered read data
- clk_out  out  NCH  per-channel square-wave outputs
- irq  out  1  OR of masked pending flags, registered

Behaviour:
- Reset (rst=0 at a clk edge): all registers, counters, prescaler, pending, d_out, clk_out, irq = 0. Reset mid-count aborts immediately; no event is generated in the reset cycle.
- Register map, channel c (c<NCH), base = 4*c:
  - +0 LIMIT_LO (RW, limit[15:0])
  - +1 LIMIT_HI (RW, limit[CW-1:16]; upper bits read 0)
  - +2 CTRL (RW): bit0 EN, bit1 PERIODIC, bit2 CLK_EN, bit3 IRQ_EN
  - +3 COUNT_LO (RO): reading latches count[CW-1:16] into the COUNT_HI shadow in the same cycle
- Global registers:
  - 16 STATUS: read = pending[NCH-1:0]; write = W1C
  - 17 COUNT_HI (RO shadow)
  - 18 PRESC (RW, PW bits)
- Unmapped addresses and channels >= NCH: read 0, writes ignored.
- Write occurs when cs&wr at a clk edge. Read occurs when cs&rd: d_out updates at that edge (1-cycle latency) and holds its value otherwise. cs&rd&wr together is treated as a write only; d_out holds.
- Prescaler: counts 0..PRESC and emits a 1-cycle tick when count==PRESC, then wraps to 0. PRESC=0 gives a tick every cycle. Writing PRESC resets the prescaler count to 0.
- Channel per tick, when EN=1 and limit!=0:
  - If count==limit: terminal event. count<=0; pending[c]<=1; if CLK_EN, clk_out[c] toggles; if PERIODIC=0, EN<=0.
  - Otherwise count<=count+1.
  - Event period = (limit+1) ticks; clk_out period = 2*(limit+1) ticks.
- limit==0: channel frozen, no events, count held at 0.
- EN 0->1 via CTRL write, or any LIMIT write: count<=0 in the same edge. Counting resumes on the next tick.
- CLK_EN=0: clk_out[c] forced to 0 on the next edge.
- Terminal event and W1C of the same bit in the same cycle: set wins, pending stays 1.
- Count wraps only through a terminal event; it never overflows, since limit <= 2^CW-1.
- irq <= |(pending & IRQ_EN mask), so irq asserts 1 cycle after pending is set and drops 1 cycle after clear or mask.

Decomposition:
- Shared package `timer_pkg` holds:
  - address constants: LIMIT_LO_OFS=0, LIMIT_HI_OFS=1, CTRL_OFS=2, COUNT_LO_OFS=3, STATUS_ADDR=16, COUNT_HI_ADDR=17, PRESC_ADDR=18
  - CTRL bit indices
- One sub-module `timer_channel`, instantiated NCH times via generate. It holds limit, ctrl, count, pending set logic and clk_out, with inputs tick, write strobes, W1C and d_in.
- The top holds the prescaler, address decode, read mux, COUNT_HI shadow and irq.

Test Plan:
- Reset/readback: hold rst=0 for 3 cycles, then read every address -> all 0. Write LIMIT_LO ch2 = 0xBEEF -> reads 0xBEEF. Read unmapped addr 25 -> 0.
- Periodic timing: PRESC=0, ch0 limit=4, CTRL=0x0B (EN|PERIODIC|IRQ_EN) -> pending[0] every 5 cycles; irq high 1 cycle after the first event. W1C STATUS=0x1 -> irq low after 1 cycle, reasserts at the next event.
- One-shot and prescaler: PRESC=2, ch1 limit=3, CTRL=0x01 -> single event 12 cycles after the write edge, then CTRL reads 0x00 and count stays 0.
- Clock output: PRESC=0, ch3 limit=1, CLK_EN|EN|PERIODIC -> clk_out[3] toggles every 2 cycles (period 4). Clear CLK_EN -> clk_out[3]=0 on the next edge.
- Boundaries:
  - limit=0 with EN -> no events.
  - W1C in the same cycle as a terminal event -> pending stays 1.
  - CW=32, limit=0x0001_0002: read COUNT_LO, then COUNT_HI -> consistent 32-bit snapshot.
- Reset mid-operation: pull rst low while ch0 is counting at count=3 -> count, clk_out and irq are 0 on the next edge, and no event appears after rst returns high until reprogrammed.
